msrh_stq_sq_sched: RTL and testbench

Store-queue commit scheduler for the LSU. It picks which committed STQ entry drives the shared SQ/L1D write pipeline next, using oldest-first priority from the STQ head. It issues one request per cycle with a valid/ready handshake and tracks each accepted request through the L1D check and update stages. Per-stage results go back to the owning entry as one-hot vectors. It sits between the `msrh_stq_entry` array and the SQ pipe, and owns the STQ head pointer.

---
 rtl/msrh_stq_sq_sched.sv | 104 ++++++++++
 tb/tb_msrh_stq_sq_sched.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_stq_sq_sched.sv
// Store-queue commit scheduler: picks the oldest committed STQ entry for the SQ/L1D pipe and routes stage results back.
// Build option: define MSRH_STQ_SCHED_IN_ORDER_EN to issue only the head entry (strict in-order L1D writes).
module msrh_stq_sq_sched #(
    parameter int unsigned ENTRY_SIZE = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [ENTRY_SIZE-1:0]         i_commit_ready,
    input  logic [ENTRY_SIZE-1:0]         i_retire,
    output logic                          o_sq_req_valid,
    output logic [ENTRY_SIZE-1:0]         o_sq_req_index_oh,
    input  logic                          i_sq_req_ready,
    output logic [ENTRY_SIZE-1:0]         o_op_accept,
    input  logic                          i_l1d_rd_miss,
    input  logic                          i_l1d_rd_conflict,
    output logic [ENTRY_SIZE-1:0]         o_rd_miss_oh,
    output logic [ENTRY_SIZE-1:0]         o_rd_conflict_oh,
    input  logic                          i_l1d_wr_conflict,
    output logic [ENTRY_SIZE-1:0]         o_wr_conflict_oh,
    output logic [$clog2(ENTRY_SIZE)-1:0] o_head_ptr
);
    localparam int unsigned HW = $clog2(ENTRY_SIZE);

    logic                  r_req_valid;
    logic [ENTRY_SIZE-1:0] r_req_oh;
    logic [ENTRY_SIZE-1:0] r_chk_oh;
    logic [ENTRY_SIZE-1:0] r_upd_oh;
    logic [HW-1:0]         r_head;

    logic                  accept;
    logic                  held_drop;
    logic [ENTRY_SIZE-1:0] cand;
    logic [ENTRY_SIZE-1:0] masked_sel;

    assign accept    = r_req_valid & i_sq_req_ready;
    // The accepted entry still shows COMMIT this cycle, so hide it from the next pick.
    assign cand      = accept ? (i_commit_ready & ~r_req_oh) : i_commit_ready;
    assign held_drop = ~|(i_commit_ready & r_req_oh);

`ifdef MSRH_STQ_SCHED_IN_ORDER_EN
    assign masked_sel = cand[r_head] ? (ENTRY_SIZE'(1) << r_head) : '0;
`else
    logic [ENTRY_SIZE-1:0] rot;
    logic [ENTRY_SIZE-1:0] pick;

    // Rotate so the head sits at bit 0; index arithmetic wraps at the power-of-two size.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            rot[i] = cand[HW'(i) + r_head];
        end
    end

    assign pick = rot & (~rot + ENTRY_SIZE'(1));

    always_comb begin
        masked_sel = '0;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            masked_sel[HW'(i) + r_head] = pick[i];
        end
    end
`endif

    // Request register: reload when empty or consumed, otherwise hold unless the entry left COMMIT.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req_valid <= 1'b0;
            r_req_oh    <= '0;
        end else if (!r_req_valid || accept) begin
            r_req_valid <= |masked_sel;
            r_req_oh    <= masked_sel;
        end else if (held_drop) begin
            r_req_valid <= 1'b0;
        end
    end

    // CHECK and UPDATE stage ownership; a CHECK miss/conflict kills the UPDATE slot.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_chk_oh <= '0;
            r_upd_oh <= '0;
        end else begin
            r_chk_oh <= accept ? r_req_oh : '0;
            r_upd_oh <= (i_l1d_rd_miss | i_l1d_rd_conflict) ? '0 : r_chk_oh;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head <= '0;
        end else if (i_retire[r_head]) begin
            r_head <= r_head + HW'(1);
        end
    end

    assign o_sq_req_valid    = r_req_valid;
    assign o_sq_req_index_oh = r_req_oh;
    assign o_op_accept       = accept ? r_req_oh : '0;
    assign o_rd_miss_oh      = i_l1d_rd_miss ? r_chk_oh : '0;
    assign o_rd_conflict_oh  = (i_l1d_rd_conflict & ~i_l1d_rd_miss) ? r_chk_oh : '0;
    assign o_wr_conflict_oh  = i_l1d_wr_conflict ? r_upd_oh : '0;
    assign o_head_ptr        = r_head;

endmodule

// File: tb/tb_msrh_stq_sq_sched.sv
// Testbench for msrh_stq_sq_sched: directed scenarios plus randomized cycles against a queue-free reference model.
// Honours MSRH_STQ_SCHED_IN_ORDER_EN to match the build of the design.
module tb_msrh_stq_sq_sched;
    localparam int unsigned E  = 16;
    localparam int unsigned HW = 4;

    logic          i_clk;
    logic          i_reset_n;
    logic [E-1:0]  i_commit_ready;
    logic [E-1:0]  i_retire;
    logic          o_sq_req_valid;
    logic [E-1:0]  o_sq_req_index_oh;
    logic          i_sq_req_ready;
    logic [E-1:0]  o_op_accept;
    logic          i_l1d_rd_miss;
    logic          i_l1d_rd_conflict;
    logic [E-1:0]  o_rd_miss_oh;
    logic [E-1:0]  o_rd_conflict_oh;
    logic          i_l1d_wr_conflict;
    logic [E-1:0]  o_wr_conflict_oh;
    logic [HW-1:0] o_head_ptr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic          m_valid;
    logic [E-1:0]  m_oh;
    logic [E-1:0]  m_chk;
    logic [E-1:0]  m_upd;
    logic [HW-1:0] m_head;

    msrh_stq_sq_sched #(.ENTRY_SIZE(E)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_commit_ready    (i_commit_ready),
        .i_retire          (i_retire),
        .o_sq_req_valid    (o_sq_req_valid),
        .o_sq_req_index_oh (o_sq_req_index_oh),
        .i_sq_req_ready    (i_sq_req_ready),
        .o_op_accept       (o_op_accept),
        .i_l1d_rd_miss     (i_l1d_rd_miss),
        .i_l1d_rd_conflict (i_l1d_rd_conflict),
        .o_rd_miss_oh      (o_rd_miss_oh),
        .o_rd_conflict_oh  (o_rd_conflict_oh),
        .i_l1d_wr_conflict (i_l1d_wr_conflict),
        .o_wr_conflict_oh  (o_wr_conflict_oh),
        .o_head_ptr        (o_head_ptr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Oldest ready entry walking forward from head (or head only when in-order).
    function automatic logic [E-1:0] m_pick(input logic [E-1:0] cr, input int head);
        logic [E-1:0] r;
        r = '0;
`ifdef MSRH_STQ_SCHED_IN_ORDER_EN
        if (cr[head]) r[head] = 1'b1;
`else
        for (int k = 0; k < int'(E); k++) begin
            int idx;
            idx = (head + k) % int'(E);
            if (cr[idx]) begin
                r[idx] = 1'b1;
                break;
            end
        end
`endif
        return r;
    endfunction

    task automatic m_clear();
        m_valid = 1'b0;
        m_oh    = '0;
        m_chk   = '0;
        m_upd   = '0;
        m_head  = '0;
    endtask

    // Advance one clock, stepping the model with the inputs seen just before the edge.
    task automatic tick();
        logic          acc, n_valid;
        logic [E-1:0]  c, sel, n_oh, n_chk, n_upd;
        logic [HW-1:0] n_head;
        acc     = m_valid && i_sq_req_ready;
        c       = acc ? (i_commit_ready & ~m_oh) : i_commit_ready;
        sel     = m_pick(c, int'(m_head));
        n_valid = m_valid;
        n_oh    = m_oh;
        if (!m_valid || acc) begin
            n_valid = (sel != '0);
            n_oh    = sel;
        end else if ((i_commit_ready & m_oh) == '0) begin
            n_valid = 1'b0;
        end
        n_chk  = acc ? m_oh : '0;
        n_upd  = (i_l1d_rd_miss || i_l1d_rd_conflict) ? '0 : m_chk;
        n_head = i_retire[m_head] ? HW'((int'(m_head) + 1) % int'(E)) : m_head;
        @(posedge i_clk);
        #1;
        if (!i_reset_n) begin
            m_clear();
        end else begin
            m_valid = n_valid;
            m_oh    = n_oh;
            m_chk   = n_chk;
            m_upd   = n_upd;
            m_head  = n_head;
        end
    endtask

    task automatic move_head(input int tgt);
        for (int k = 0; k < int'(E) && int'(m_head) != tgt; k++) begin
            i_retire = '0;
            i_retire[m_head] = 1'b1;
            tick();
        end
        i_retire = '0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_commit_ready = '0; i_retire = '0; i_sq_req_ready = 1'b0;
        i_l1d_rd_miss = 1'b0; i_l1d_rd_conflict = 1'b0; i_l1d_wr_conflict = 1'b0;
        m_clear();
        tick(); tick();
        i_reset_n = 1'b1;
        #2;
        checks++;
        if ({o_sq_req_valid, o_sq_req_index_oh, o_op_accept, o_rd_miss_oh, o_rd_conflict_oh,
             o_wr_conflict_oh, o_head_ptr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs valid=%0b oh=%h head=%0d required all zero",
                     o_sq_req_valid, o_sq_req_index_oh, o_head_ptr);
        end
        tick();
        move_head(2);
        #2;
        checks++;
        if (o_head_ptr !== 4'd2) begin
            failures++;
            $display("FAIL reset_head_advance got=%0d exp=2", o_head_ptr);
        end
        i_commit_ready = 16'h0004;
        #2;
        checks++;
        if (o_sq_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_latency_early got=%0b exp=0", o_sq_req_valid);
        end
        tick();
        #2;
        checks++;
        if (o_sq_req_valid !== 1'b1 || o_sq_req_index_oh !== 16'h0004) begin
            failures++;
            $display("FAIL reset_first_request valid=%0b oh=%h exp valid=1 oh=0004",
                     o_sq_req_valid, o_sq_req_index_oh);
        end
        i_reset_n = 1'b0;
        #1;
        m_clear();
        checks++;
        if ({o_sq_req_valid, o_sq_req_index_oh, o_op_accept, o_head_ptr} !== '0) begin
            failures++;
            $display("FAIL reset_async valid=%0b oh=%h acc=%h head=%0d required all zero",
                     o_sq_req_valid, o_sq_req_index_oh, o_op_accept, o_head_ptr);
        end
        i_commit_ready = '0;
        tick();
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        move_head(5);
        i_commit_ready = 16'h0081;
        i_sq_req_ready = 1'b1;
        #2;
        checks++;
        if (o_sq_req_valid !== 1'b0 || o_head_ptr !== 4'd5) begin
            failures++;
            $display("FAIL prio_start valid=%0b head=%0d exp valid=0 head=5", o_sq_req_valid, o_head_ptr);
        end
        tick();
`ifdef MSRH_STQ_SCHED_IN_ORDER_EN
        for (int k = 0; k < 2; k++) begin
            #2;
            checks++;
            if (o_sq_req_valid !== 1'b0 || o_op_accept !== '0) begin
                failures++;
                $display("FAIL prio_inorder_wait valid=%0b acc=%h exp valid=0", o_sq_req_valid, o_op_accept);
            end
            tick();
        end
        i_commit_ready = 16'h00A1;
        tick();
        #2;
        checks++;
        if (o_op_accept !== 16'h0020) begin
            failures++;
            $display("FAIL prio_inorder_head got=%h exp=0020", o_op_accept);
        end
        tick();
        i_commit_ready = 16'h0081;
        #2;
        checks++;
        if (o_sq_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_inorder_after got=%0b exp=0", o_sq_req_valid);
        end
`else
        #2;
        checks++;
        if (o_op_accept !== 16'h0080) begin
            failures++;
            $display("FAIL prio_first got=%h exp=0080", o_op_accept);
        end
        tick();
        i_commit_ready = 16'h0001;
        #2;
        checks++;
        if (o_op_accept !== 16'h0001) begin
            failures++;
            $display("FAIL prio_second got=%h exp=0001", o_op_accept);
        end
        tick();
        i_commit_ready = '0;
        #2;
        checks++;
        if (o_sq_req_valid !== 1'b0 || o_op_accept !== '0) begin
            failures++;
            $display("FAIL prio_no_dup valid=%0b acc=%h exp valid=0 acc=0", o_sq_req_valid, o_op_accept);
        end
`endif
        i_commit_ready = '0;
        i_sq_req_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [E-1:0] exp6;
        move_head(1);
        i_commit_ready = 16'h0006;
        i_sq_req_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            #2;
            checks++;
            if (o_sq_req_valid !== 1'b1 || o_sq_req_index_oh !== 16'h0002 || o_op_accept !== '0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%0b oh=%h acc=%h exp valid=1 oh=0002 acc=0",
                         k, o_sq_req_valid, o_sq_req_index_oh, o_op_accept);
            end
            tick();
        end
        i_sq_req_ready = 1'b1;
        #2;
        checks++;
        if (o_op_accept !== 16'h0002) begin
            failures++;
            $display("FAIL bp_release got=%h exp=0002", o_op_accept);
        end
        tick();
        i_commit_ready = 16'h0004;
`ifdef MSRH_STQ_SCHED_IN_ORDER_EN
        exp6 = '0;
`else
        exp6 = 16'h0004;
`endif
        #2;
        checks++;
        if (o_op_accept !== exp6) begin
            failures++;
            $display("FAIL bp_next got=%h exp=%h", o_op_accept, exp6);
        end
        tick();
        i_commit_ready = '0;
        i_sq_req_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_stage_routing();
        move_head(3);
        for (int mode = 0; mode < 3; mode++) begin
            i_commit_ready = 16'h0008;
            i_sq_req_ready = 1'b1;
            #2;
            checks++;
            if (o_sq_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL stage_replay_early mode=%0d got=%0b exp=0", mode, o_sq_req_valid);
            end
            tick();
            #2;
            checks++;
            if (o_op_accept !== 16'h0008) begin
                failures++;
                $display("FAIL stage_accept mode=%0d got=%h exp=0008", mode, o_op_accept);
            end
            tick();
            i_commit_ready    = '0;
            i_l1d_rd_miss     = (mode == 0);
            i_l1d_rd_conflict = (mode != 1);
            #2;
            checks++;
            if (o_rd_miss_oh !== ((mode == 0) ? 16'h0008 : 16'h0000) ||
                o_rd_conflict_oh !== ((mode == 2) ? 16'h0008 : 16'h0000)) begin
                failures++;
                $display("FAIL stage_check mode=%0d miss=%h conf=%h", mode, o_rd_miss_oh, o_rd_conflict_oh);
            end
            tick();
            i_l1d_rd_miss     = 1'b0;
            i_l1d_rd_conflict = 1'b0;
            i_l1d_wr_conflict = 1'b1;
            #2;
            checks++;
            if (o_wr_conflict_oh !== ((mode == 1) ? 16'h0008 : 16'h0000)) begin
                failures++;
                $display("FAIL stage_update mode=%0d got=%h", mode, o_wr_conflict_oh);
            end
            tick();
            i_l1d_wr_conflict = 1'b0;
            i_sq_req_ready    = 1'b0;
            tick();
        end
    endtask

    task automatic test_head_wrap();
        move_head(15);
        #2;
        checks++;
        if (o_head_ptr !== 4'd15) begin
            failures++;
            $display("FAIL wrap_start got=%0d exp=15", o_head_ptr);
        end
        i_retire = 16'h8001;
        tick();
        #2;
        checks++;
        if (o_head_ptr !== 4'd0) begin
            failures++;
            $display("FAIL wrap_to_zero got=%0d exp=0", o_head_ptr);
        end
        i_retire = 16'h0001;
        tick();
        #2;
        checks++;
        if (o_head_ptr !== 4'd1) begin
            failures++;
            $display("FAIL wrap_to_one got=%0d exp=1", o_head_ptr);
        end
        i_retire = 16'h0010;
        tick();
        #2;
        checks++;
        if (o_head_ptr !== 4'd1) begin
            failures++;
            $display("FAIL wrap_non_head got=%0d exp=1", o_head_ptr);
        end
        i_retire = '0;
        tick();
    endtask

    task automatic test_random();
        logic [100:0] got, exp;
        logic [E-1:0] noise;
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            i_commit_ready    = E'($urandom & $urandom);
            noise             = E'($urandom & $urandom & $urandom);
            i_retire          = noise;
            if ($urandom_range(0, 2) == 0) i_retire[m_head] = 1'b1;
            i_sq_req_ready    = ($urandom_range(0, 3) != 0);
            i_l1d_rd_miss     = ($urandom_range(0, 3) == 0);
            i_l1d_rd_conflict = ($urandom_range(0, 3) == 0);
            i_l1d_wr_conflict = ($urandom_range(0, 2) == 0);
            #2;
            exp = {m_valid, m_oh,
                   (m_valid && i_sq_req_ready) ? m_oh : E'(0),
                   i_l1d_rd_miss ? m_chk : E'(0),
                   (i_l1d_rd_conflict && !i_l1d_rd_miss) ? m_chk : E'(0),
                   i_l1d_wr_conflict ? m_upd : E'(0),
                   m_head};
            got = {o_sq_req_valid, o_sq_req_index_oh, o_op_accept, o_rd_miss_oh,
                   o_rd_conflict_oh, o_wr_conflict_oh, o_head_ptr};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
            tick();
        end
        i_commit_ready = '0; i_retire = '0; i_sq_req_ready = 1'b0;
        i_l1d_rd_miss = 1'b0; i_l1d_rd_conflict = 1'b0; i_l1d_wr_conflict = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_backpressure();
        test_stage_routing();
        test_head_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
